// File: rtl/poly_arb_pkg.sv
`default_nettype none
// ==================================================================
// poly_arb_pkg: default widths, Q-format scales and tag sizing. Rev 1.0
// ==================================================================
package poly_arb_pkg;

  localparam int N_REQ_DEF     = 4;
  localparam int WIDTHIN_DEF   = 16;
  localparam int WIDTHOUT_DEF  = 32;
  localparam int TAG_DEPTH_DEF = 8;

  localparam int X_FRAC_BITS = 14;  // Q2.14 operands
  localparam int Y_FRAC_BITS = 25;  // Q7.25 results
  localparam logic [WIDTHOUT_DEF-1:0] Y_ONE = 32'h0200_0000;

  function automatic int tag_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/poly_eval_arbiter_if.sv
`default_nettype none
// ==================================================================
// poly_eval_arbiter_if: requester and evaluator handshakes. Rev 1.0
// ==================================================================
interface poly_eval_arbiter_if
  import poly_arb_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int WIDTHIN  = WIDTHIN_DEF,
  parameter int WIDTHOUT = WIDTHOUT_DEF
);
  logic [N_REQ-1:0]          req_valid;
  logic [N_REQ-1:0]          req_ready;
  logic [N_REQ*WIDTHIN-1:0]  req_x;
  logic [N_REQ-1:0]          rsp_valid;
  logic [N_REQ-1:0]          rsp_ready;
  logic [N_REQ*WIDTHOUT-1:0] rsp_y;
  logic                      ev_valid;
  logic                      ev_ready;
  logic [WIDTHIN-1:0]        ev_x;
  logic                      ev_y_valid;
  logic                      ev_y_ready;
  logic [WIDTHOUT-1:0]       ev_y;

  // Environment side: requesters plus the evaluator instance.
  modport master (
    output req_valid, req_x, rsp_ready, ev_ready, ev_y_valid, ev_y,
    input  req_ready, rsp_valid, rsp_y, ev_valid, ev_x, ev_y_ready
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_x, rsp_ready, ev_ready, ev_y_valid, ev_y,
    output req_ready, rsp_valid, rsp_y, ev_valid, ev_x, ev_y_ready
  );
endinterface
`default_nettype wire

// File: rtl/poly_tag_fifo.sv
`default_nettype none
// ==================================================================
// poly_tag_fifo: in-order tag FIFO with registered full/empty. Rev 1.0
// ==================================================================
module poly_tag_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      // Flags derive from the pre-update count, so they land with it.
      case ({do_push, do_pop})
        2'b10: begin
          count <= count + CW'(1);
          empty <= 1'b0;
          full  <= (count == LAST);
        end
        2'b01: begin
          count <= count - CW'(1);
          full  <= 1'b0;
          empty <= (count == CW'(1));
        end
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: rtl/poly_eval_arbiter.sv
`default_nettype none
// ==================================================================
// poly_eval_arbiter: round-robin sharing of one exp evaluator; define
// POLY_ARB_RSP_REG_EN to register the response path. Rev 1.0
// ==================================================================
module poly_eval_arbiter
  import poly_arb_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int WIDTHIN   = WIDTHIN_DEF,
  parameter int WIDTHOUT  = WIDTHOUT_DEF,
  parameter int TAG_DEPTH = TAG_DEPTH_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  poly_eval_arbiter_if.slave             bus,
  output logic [$clog2(TAG_DEPTH+1)-1:0] outstanding,
  output logic                           err_orphan
);
  localparam int TW = tag_width(N_REQ);

  logic [TW-1:0] rr_ptr;
  logic [TW-1:0] grant;
  logic [TW-1:0] fifo_head;
  logic [TW-1:0] head;
  logic          found;
  int            idx;
  logic          any_req;
  logic          fifo_full;
  logic          fifo_empty;
  logic          issue;
  logic          retire;
  logic          orphan;

  always_comb begin
    found = 1'b0;
    grant = rr_ptr;
    idx   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % N_REQ;
      if (!found && bus.req_valid[idx]) begin
        grant = TW'(idx);
        found = 1'b1;
      end
    end
  end

  assign any_req      = |bus.req_valid;
  assign bus.ev_valid = any_req && !fifo_full;
  assign bus.ev_x     = bus.req_x[int'(grant)*WIDTHIN +: WIDTHIN];
  assign issue        = bus.ev_valid && bus.ev_ready;

  always_comb begin
    bus.req_ready        = '0;
    bus.req_ready[grant] = any_req && bus.ev_ready && !fifo_full;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (issue) begin
      rr_ptr <= (grant == TW'(N_REQ - 1)) ? '0 : grant + TW'(1);
    end
  end

  poly_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .WIDTH (TW)
  ) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (issue),
    .pop   (retire),
    .din   (grant),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (outstanding)
  );

  // An empty FIFO's head slot holds a stale tag; steer to requester 0.
  assign head   = fifo_empty ? '0 : fifo_head;
  assign orphan = bus.ev_y_valid && fifo_empty;
  assign retire = bus.ev_y_valid && bus.ev_y_ready && !fifo_empty;

`ifdef POLY_ARB_RSP_REG_EN
  logic                reg_valid;
  logic [TW-1:0]       reg_tag;
  logic [WIDTHOUT-1:0] reg_y;

  assign bus.ev_y_ready = orphan || !reg_valid || bus.rsp_ready[reg_tag];

  always_ff @(posedge clk) begin
    if (!reset) begin
      reg_valid <= 1'b0;
      reg_tag   <= '0;
    end else if (retire) begin
      reg_valid <= 1'b1;
      reg_tag   <= head;
    end else if (bus.rsp_ready[reg_tag]) begin
      reg_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (retire) reg_y <= bus.ev_y;
  end

  always_comb begin
    bus.rsp_valid          = '0;
    bus.rsp_valid[reg_tag] = reg_valid;
  end

  assign bus.rsp_y = {N_REQ{reg_y}};
`else
  assign bus.ev_y_ready = orphan || bus.rsp_ready[head];

  always_comb begin
    bus.rsp_valid       = '0;
    bus.rsp_valid[head] = bus.ev_y_valid && !fifo_empty;
  end

  assign bus.rsp_y = {N_REQ{bus.ev_y}};
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      err_orphan <= 1'b0;
    end else if (orphan) begin
      err_orphan <= 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_poly_eval_arbiter.sv
`default_nettype none
// ==================================================================
// tb_poly_eval_arbiter: directed stimulus, queue scoreboard. Rev 1.0
// ==================================================================
module tb_poly_eval_arbiter;
  import poly_arb_pkg::*;

  localparam int N   = 4;
  localparam int WI  = 16;
  localparam int WO  = 32;
  localparam int TD  = 8;
  localparam int LAT = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] outstanding;
  logic       err_orphan;

  always #5 clk = ~clk;

  poly_eval_arbiter_if #(.N_REQ(N), .WIDTHIN(WI), .WIDTHOUT(WO)) bus ();

  poly_eval_arbiter #(
    .N_REQ     (N),
    .WIDTHIN   (WI),
    .WIDTHOUT  (WO),
    .TAG_DEPTH (TD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .outstanding (outstanding),
    .err_orphan  (err_orphan)
  );

  int nchk = 0;
  int nerr = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // 5th-order exp Taylor series, Q2.14 unsigned in, Q7.25 out.
  function automatic logic [WO-1:0] taylor(input logic [WI-1:0] x);
    real v, t, s;
    v = real'(x) / 16384.0;
    s = 1.0;
    t = 1.0;
    for (int n = 1; n <= 5; n++) begin
      t = t * v / n;
      s = s + t;
    end
    return WO'($rtoi(s * 33554432.0 + 0.5));
  endfunction

  function automatic int grant_ref(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++) if (v[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  // ---------------- evaluator model: fixed latency, elastic output queue
  typedef struct { logic [WO-1:0] y; int due; } ev_item_t;
  ev_item_t      evq[$];
  int            cyc     = 0;
  logic          m_valid = 1'b0;
  logic [WO-1:0] m_y     = '0;
  logic          inj     = 1'b0;

  assign bus.ev_y_valid = m_valid | inj;
  assign bus.ev_y       = m_y;

  always begin
    @(posedge clk);
    if (!reset) begin
      evq.delete();
    end else begin
      if (m_valid && bus.ev_y_ready) void'(evq.pop_front());
      if (bus.ev_valid && bus.ev_ready) evq.push_back('{taylor(bus.ev_x), cyc + LAT});
    end
    cyc++;
    #1;
    m_valid = (evq.size() > 0) && (evq[0].due <= cyc);
    m_y     = m_valid ? evq[0].y : '0;
  end

  // ---------------- scoreboard: issue pushes, retire pops and compares
  typedef struct { int k; logic [WO-1:0] y; } sb_item_t;
  sb_item_t      sb[$];
  int            grant_log[$];
  logic [WO-1:0] y0_log[$];
  int            rsp_cnt [N];
  int            rr_ref = 0;
  int            mon_g;
  sb_item_t      mon_e;

  always @(posedge clk) begin
    if (!reset) begin
      sb.delete();
      rr_ref = 0;
    end else begin
      check("rsp_onehot", 64'($onehot0(bus.rsp_valid)), 64'd1);
      if (bus.ev_valid && bus.ev_ready) begin
        check("issue_has_req", 64'(|bus.req_valid), 64'd1);
        mon_g = grant_ref(bus.req_valid, rr_ref);
        if (mon_g < 0) mon_g = 0;
        check("grant", 64'(bus.req_ready), 64'd1 << mon_g);
        check("ev_x", 64'(bus.ev_x), 64'(bus.req_x[mon_g*WI +: WI]));
        sb.push_back('{mon_g, taylor(bus.req_x[mon_g*WI +: WI])});
        grant_log.push_back(mon_g);
        rr_ref = (mon_g + 1) % N;
      end
      for (int k = 0; k < N; k++) begin
        if (bus.rsp_valid[k] && bus.rsp_ready[k]) begin
          if (sb.size() == 0) begin
            nchk++;
            nerr++;
            $display("FAIL rsp_unexpected: requester %0d got 0x%0h, expected no result", k, bus.rsp_y[k*WO +: WO]);
          end else begin
            mon_e = sb.pop_front();
            check("rsp_route", 64'(k), 64'(mon_e.k));
            check("rsp_y", 64'(bus.rsp_y[k*WO +: WO]), 64'(mon_e.y));
            rsp_cnt[k]++;
            if (k == 0) y0_log.push_back(bus.rsp_y[WO-1:0]);
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers
  task automatic send(input int k, input logic [WI-1:0] x);
    int n;
    @(posedge clk); #1;
    bus.req_x[k*WI +: WI] = x;
    bus.req_valid[k]      = 1'b1;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.req_ready[k]) break;
    end
    if (n == 50) begin
      nchk++;
      nerr++;
      $display("FAIL send_timeout: requester %0d never accepted, expected acceptance", k);
    end
    @(posedge clk); #1;
    bus.req_valid[k] = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (outstanding == 0 && sb.size() == 0 && evq.size() == 0) break;
    end
    check({name, "_outstanding"}, 64'(outstanding), 64'd0);
    check({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  int            c1, c3, n_iss, gk, budget;
  logic [WI-1:0] stall_x;
  real           yv;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b0;
    bus.req_valid = '0;
    bus.req_x     = '0;
    bus.rsp_ready = 4'b1110;
    bus.ev_ready  = 1'b1;
    repeat (3) @(posedge clk);

    // Reset state
    @(negedge clk);
    check("rst_ev_valid", 64'(bus.ev_valid), 64'd0);
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_outstanding", 64'(outstanding), 64'd0);
    check("rst_err_orphan", 64'(err_orphan), 64'd0);
    check("rst_ev_y_ready_0", 64'(bus.ev_y_ready), 64'd0);
    bus.rsp_ready = 4'b0001;
    #1;
    check("rst_ev_y_ready_1", 64'(bus.ev_y_ready), 64'd1);
    @(posedge clk); #1;
    reset         = 1'b1;
    bus.rsp_ready = 4'hF;

    // Single requester: exp(0) and exp(2)
    send(0, 16'h0000);
    send(0, 16'h8000);
    drain("single");
    check("single_count", 64'(y0_log.size()), 64'd2);
    if (y0_log.size() >= 2) begin
      check("exp0_exact", 64'(y0_log[0]), 64'h0200_0000);
      yv = real'(y0_log[1]) / 33554432.0;
      check("exp2_tol", 64'((yv > 7.222) && (yv < 7.312)), 64'd1);
    end

    // All four requesters every cycle: strict rotation from 0
    pulse_reset();
    grant_log.delete();
    c1 = rsp_cnt[1];
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) bus.req_x[k*WI +: WI] = WI'(16'h0100 * (k + 1));
    bus.req_valid = 4'hF;
    n_iss  = 0;
    budget = 0;
    while (n_iss < 12 && budget < 100) begin
      @(negedge clk);
      budget++;
      if (|bus.req_ready) begin
        n_iss++;
        gk = 0;
        for (int k = 0; k < N; k++) if (bus.req_ready[k]) gk = k;
        @(posedge clk); #1;
        if (n_iss == 12) bus.req_valid = '0;
        else bus.req_x[gk*WI +: WI] = bus.req_x[gk*WI +: WI] + 16'h0011;
      end
    end
    check("rr_issue_count", 64'(n_iss), 64'd12);
    drain("rr");
    for (int i = 0; i < 12; i++)
      if (i < grant_log.size()) check("rr_order", 64'(grant_log[i]), 64'(i % 4));
    check("rr_rsp_count_1", 64'(rsp_cnt[1] - c1), 64'd3);

    // Head-of-line stall on requester 2 until the tag FIFO fills
    bus.rsp_ready = 4'b1011;
    send(2, 16'h2000);
    @(posedge clk); #1;
    bus.req_x[0*WI +: WI] = 16'h0800;
    bus.req_x[1*WI +: WI] = 16'h0900;
    bus.req_x[3*WI +: WI] = 16'h0A00;
    bus.req_valid = 4'b1011;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (outstanding == 4'd8) break;
    end
    check("full_outstanding", 64'(outstanding), 64'd8);
    check("full_ev_valid", 64'(bus.ev_valid), 64'd0);
    check("stall_ev_y_ready", 64'(bus.ev_y_ready), 64'd0);
    check("stall_rsp_valid", 64'(bus.rsp_valid), 64'b0100);
    repeat (3) begin
      @(negedge clk);
      check("full_hold", 64'(outstanding), 64'd8);
      check("full_hold_ev_valid", 64'(bus.ev_valid), 64'd0);
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    bus.rsp_ready = 4'hF;
    drain("hol");

    // Evaluator not ready: grant must hold across the stall
    pulse_reset();
    @(posedge clk); #1;
    bus.ev_ready = 1'b0;
    for (int k = 0; k < N; k++) bus.req_x[k*WI +: WI] = WI'(16'h1000 * (k + 1));
    bus.req_valid = 4'hF;
    @(negedge clk);
    stall_x = bus.ev_x;
    check("evstall_ev_valid", 64'(bus.ev_valid), 64'd1);
    check("evstall_ev_x", 64'(stall_x), 64'h1000);
    repeat (2) begin
      @(negedge clk);
      check("evstall_req_ready", 64'(bus.req_ready), 64'd0);
      check("evstall_grant_hold", 64'(bus.ev_x), 64'h1000);
    end
    @(posedge clk); #1;
    bus.ev_ready = 1'b1;
    @(negedge clk);
    check("evstall_resume", 64'(bus.req_ready), 64'b0001);
    @(posedge clk); #1;
    bus.req_valid = '0;
    drain("evstall");

    // Orphan result with empty FIFO
    @(posedge clk); #1;
    inj = 1'b1;
    @(negedge clk);
    check("orphan_ev_y_ready", 64'(bus.ev_y_ready), 64'd1);
    check("orphan_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    @(posedge clk); #1;
    inj = 1'b0;
    @(negedge clk);
    check("orphan_set", 64'(err_orphan), 64'd1);
    repeat (3) @(negedge clk);
    check("orphan_sticky", 64'(err_orphan), 64'd1);
    pulse_reset();
    @(negedge clk);
    check("orphan_cleared", 64'(err_orphan), 64'd0);

    // Reset with five tags outstanding, then fresh traffic
    bus.rsp_ready = 4'h0;
    send(0, 16'h0400);
    send(1, 16'h0500);
    send(2, 16'h0600);
    send(3, 16'h0700);
    send(0, 16'h0401);
    @(negedge clk);
    check("pre_rst_outstanding", 64'(outstanding), 64'd5);
    pulse_reset();
    @(negedge clk);
    check("post_rst_outstanding", 64'(outstanding), 64'd0);
    check("post_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    bus.rsp_ready = 4'hF;
    c1 = rsp_cnt[1];
    c3 = rsp_cnt[3];
    send(1, 16'h3000);
    send(3, 16'h0001);
    drain("post_rst");
    check("post_rst_cnt_1", 64'(rsp_cnt[1] - c1), 64'd1);
    check("post_rst_cnt_3", 64'(rsp_cnt[3] - c3), 64'd1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/poly_eval_arbiter.md
# poly_eval_arbiter

Shares one pipelined polynomial (exp Taylor) evaluator among N_REQ requesters. Each cycle it picks one valid requester round-robin, issues its Q2.14 operand to the evaluator, and records the requester index in an in-order tag FIFO. As Q7.25 results emerge, it pops the head tag and routes each result back to the requester that issued it. It sits between the requester fabric and a single evaluator instance that uses the valid/ready handshake.

## Interface
- N_REQ, 4: number of requesters (2..8)
- WIDTHIN, 16: operand width, Q2.14
- WIDTHOUT, 32: result width, Q7.25
- TAG_DEPTH, 8: maximum outstanding operations (power of two)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low
- req_valid  in  N_REQ  requester k has an operand
- req_ready  out  N_REQ  operand of requester k accepted this cycle
- req_x  in  N_REQ*WIDTHIN  packed operands; requester k at [k*WIDTHIN +: WIDTHIN]
- rsp_valid  out  N_REQ  result for requester k present
- rsp_ready  in  N_REQ  requester k takes its result
- rsp_y  out  N_REQ*WIDTHOUT  packed results, same slicing as req_x
- ev_valid  out  1  drives evaluator i_valid
- ev_ready  in  1  evaluator o_ready
- ev_x  out  WIDTHIN  drives evaluator i_x
- ev_y_valid  in  1  evaluator o_valid
- ev_y_ready  out  1  drives evaluator i_ready
- ev_y  in  WIDTHOUT  evaluator o_y
- outstanding  out  clog2(TAG_DEPTH+1)  tags in flight
- err_orphan  out  1  sticky: a result arrived with no tag

## Operation
- Issue: the grant g is the first k with req_valid[k], searching from rr_ptr upward and wrapping. ev_valid = |req_valid && !fifo_full. ev_x = req_x[g].
- req_ready[g] = ev_ready && !fifo_full. Every other req_ready bit is 0.
- An issue fires when ev_valid && ev_ready. On issue, push g into the tag FIFO and set rr_ptr = (g+1) mod N_REQ. With no issue, rr_ptr holds.
- Retire: head = FIFO head tag. rsp_valid[head] = ev_y_valid && !fifo_empty. rsp_y carries ev_y on every slice; only the head slice is qualified. ev_y_ready = rsp_ready[head].
- A retire fires when ev_y_valid && ev_y_ready && !fifo_empty. On retire, pop the FIFO.
- Orphan: if ev_y_valid while the FIFO is empty, drive ev_y_ready = 1, discard the result, and set err_orphan. err_orphan clears only on reset.
- outstanding tracks the FIFO occupancy: +1 on issue, −1 on retire, unchanged on a simultaneous issue and retire.
- Arithmetic: no transformation of data. Operands and results pass bit-exact.

## Timing
- Reset (reset=0 at a clk edge): rr_ptr=0, FIFO empty, outstanding=0, err_orphan=0. Resulting outputs: ev_valid=0, req_ready=0, rsp_valid=0, ev_y_ready=rsp_ready[0].
- Reset mid-operation discards all tags. The evaluator must be reset in the same cycle; results from pre-reset issues are otherwise reported as orphans.
- Latency added by the arbiter is 0 cycles on the issue path and 0 cycles on the response path (without the macro). End-to-end latency equals the evaluator's latency.
- FIFO full: issue is blocked. A retire in the same cycle does not unblock issue until the next cycle; full is registered.
- FIFO empty: no rsp_valid is asserted.
- An issue and a retire may occur in the same cycle at any occupancy except full, which permits retire only.
- A stalled requester (rsp_ready=0) back-pressures the evaluator and therefore all requesters. This head-of-line blocking is intended.
- Throughput: one issue per cycle when ev_ready stays high.

## Configuration
- POLY_ARB_RSP_REG_EN defined: adds a one-entry response register {valid, tag, y} between the evaluator and the requesters.
  - Response latency becomes +1 cycle.
  - ev_y_ready = !reg_valid || rsp_ready[reg_tag].
  - rsp_* are driven from the register, which removes the combinational rsp_ready→ev_y_ready path. Full throughput is kept.
  - The register's valid bit resets to 0.
- Undefined: the combinational routing described in Operation.

## Structure
- Package poly_arb_pkg holds:
  - The default widths and Q-format scale constants (Q2.14, Q7.25).
  - A tag-width function, clog2(N_REQ).
  - The default TAG_DEPTH.
- One sub-module, poly_tag_fifo: a synchronous FIFO of TAG_DEPTH × tag width with push/pop, registered full/empty flags, and a count output.
- Round-robin grant and routing logic stay in the top module.

## Test plan
- Single requester 0, x=0x0000 then x=0x8000 → rsp_y on slice 0 = 0x0200_0000 (1.0), then ≈7.267 (within 0.045). outstanding returns to 0.
- All four requesters valid every cycle with distinct x → grants in order 0,1,2,3,0… Each requester receives exactly its own results, in its own issue order.
- Hold rsp_ready[2]=0 for 6 cycles while requester 2's result is at the head → ev_y_ready=0, no result lost, and issue continues until outstanding=8. Then ev_valid=0 until retire resumes.
- Force ev_ready=0 for 3 cycles → req_ready all 0 and rr_ptr unchanged. The same requester is granted once ev_ready returns.
- Inject ev_y_valid=1 with the FIFO empty → err_orphan=1 the next cycle and stays 1. Assert reset=0 → err_orphan=0.
- Assert reset=0 with 5 tags outstanding → outstanding=0 and all rsp_valid=0 the next cycle. Post-reset traffic routes correctly.
